// File: rtl/demux18_reg.sv
// Registered 1-to-8 demultiplexer: routes one W-bit word into one of eight
// holding lanes (explicit select or round-robin pointer), each released by an ack.
module demux18_reg #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     sel,
  input  logic           auto,
  output logic [2:0]     ptr,
  output logic [8*W-1:0] out_bus,
  output logic [7:0]     out_valid,
  input  logic [7:0]     out_ack,
  output logic           frame_done
);

  logic [2:0]     ptr_q, ptr_d;
  logic [8*W-1:0] bus_q, bus_d;
  logic [7:0]     valid_q, valid_d;
  logic           frame_q, frame_d;
  logic [2:0]     tgt;
  logic           wr;

  always_comb begin
    tgt      = auto ? ptr_q : sel;
    // A full lane can still accept when its consumer takes the old word now.
    in_ready = ~valid_q[tgt] | out_ack[tgt];
    wr       = in_valid & in_ready;

    valid_d  = valid_q & ~out_ack;
    bus_d    = bus_q;
    ptr_d    = ptr_q;
    frame_d  = 1'b0;
    if (wr) begin
      valid_d[tgt]              = 1'b1;
      bus_d[int'(tgt)*W +: W]   = in_data;
      if (auto) begin
        ptr_d   = ptr_q + 3'd1;
        frame_d = (ptr_q == 3'd7);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q   <= 3'd0;
      bus_q   <= '0;
      valid_q <= 8'h00;
      frame_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      bus_q   <= bus_d;
      valid_q <= valid_d;
      frame_q <= frame_d;
    end
  end

  assign ptr        = ptr_q;
  assign out_bus    = bus_q;
  assign out_valid  = valid_q;
  assign frame_done = frame_q;

endmodule

// File: tb/tb_demux18_reg.sv
// Bench for demux18_reg: lane/array model checked every cycle plus directed
// scenarios with literal expectations.
module tb_demux18_reg;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     sel;
  logic           auto;
  logic [2:0]     ptr;
  logic [8*W-1:0] out_bus;
  logic [7:0]     out_valid;
  logic [7:0]     out_ack;
  logic           frame_done;

  demux18_reg #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .auto(auto), .ptr(ptr),
    .out_bus(out_bus), .out_valid(out_valid), .out_ack(out_ack),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Model: eight lanes as an array, a pointer as an integer.
  logic [W-1:0] m_lane [8];
  bit           m_valid [8];
  int           m_ptr;
  bit           m_frame;
  bit           started = 0;

  always @(posedge clk) begin
    int t;
    bit acc;
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) begin m_lane[k] = '0; m_valid[k] = 0; end
      m_ptr = 0; m_frame = 0;
    end else begin
      t = auto ? m_ptr : int'(sel);
      acc = in_valid && (!m_valid[t] || out_ack[t]);
      for (int k = 0; k < 8; k++) if (m_valid[k] && out_ack[k]) m_valid[k] = 0;
      m_frame = acc && auto && (m_ptr == 7);
      if (acc) begin
        m_lane[t] = in_data;
        m_valid[t] = 1;
        if (auto) m_ptr = (m_ptr + 1) % 8;
      end
    end
    started = 1;
  end

  always @(negedge clk) begin
    logic [63:0] e_bus;
    logic [7:0]  e_val;
    int t;
    if (started) begin
      for (int k = 0; k < 8; k++) begin
        e_bus[k*8 +: 8] = m_lane[k];
        e_val[k] = m_valid[k];
      end
      t = auto ? m_ptr : int'(sel);
      check("cyc_out_bus", out_bus, e_bus);
      check("cyc_out_valid", {56'd0, out_valid}, {56'd0, e_val});
      check("cyc_ptr", {61'd0, ptr}, 64'(m_ptr));
      check("cyc_frame_done", {63'd0, frame_done}, {63'd0, m_frame});
      check("cyc_in_ready", {63'd0, in_ready}, {63'd0, (!m_valid[t] || out_ack[t])});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lane(input int k);
    return out_bus[k*8 +: 8];
  endfunction

  initial begin
    rst_n = 0; in_data = 8'hFF; in_valid = 1; sel = 3'd0; auto = 0; out_ack = 8'h00;
    step(); step();
    check("rst_valid", {56'd0, out_valid}, 64'h00);
    check("rst_ptr", {61'd0, ptr}, 64'd0);
    check("rst_frame", {63'd0, frame_done}, 64'd0);
    check("rst_bus", out_bus, 64'd0);
    rst_n = 1; in_valid = 0;
    step();

    // Manual routing
    in_data = 8'hA5; sel = 3'd5; in_valid = 1;
    step();
    in_valid = 0;
    check("man_valid", {56'd0, out_valid}, 64'h20);
    check("man_lane5", {56'd0, lane(5)}, 64'hA5);
    out_ack = 8'h20;
    step();
    out_ack = 8'h00;
    check("man_rel_valid", {56'd0, out_valid}, 64'h00);
    check("man_rel_lane5", {56'd0, lane(5)}, 64'hA5);

    // Auto deserialize with all lanes acked
    auto = 1; out_ack = 8'hFF; in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'((i + 1) * 8'h11);
      #1;
      check("auto_ready", {63'd0, in_ready}, 64'd1);
      step();
    end
    in_valid = 0;
    check("auto_frame_hi", {63'd0, frame_done}, 64'd1);
    check("auto_ptr_wrap", {61'd0, ptr}, 64'd0);
    for (int i = 0; i < 8; i++) check("auto_lane", {56'd0, lane(i)}, 64'((i + 1) * 8'h11));
    step();
    check("auto_frame_lo", {63'd0, frame_done}, 64'd0);
    out_ack = 8'h00;

    // Backpressure
    in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'(8'h40 + i);
      step();
    end
    in_data = 8'h99;
    #1;
    check("bp_ready0", {63'd0, in_ready}, 64'd0);
    check("bp_valid_ff", {56'd0, out_valid}, 64'hFF);
    check("bp_ptr0", {61'd0, ptr}, 64'd0);
    step();
    check("bp_hold_ptr", {61'd0, ptr}, 64'd0);
    check("bp_hold_lane0", {56'd0, lane(0)}, 64'h40);
    out_ack = 8'h01;
    #1;
    check("bp_ready1", {63'd0, in_ready}, 64'd1);
    step();
    out_ack = 8'h00; in_valid = 0;
    check("bp_lane0", {56'd0, lane(0)}, 64'h99);
    check("bp_ptr1", {61'd0, ptr}, 64'd1);
    check("bp_valid", {56'd0, out_valid}, 64'hFF);

    // Ack and write on the same lane, plus write-one/ack-other
    out_ack = 8'hFF;
    step();
    out_ack = 8'h00; auto = 0; sel = 3'd3; in_data = 8'h3C; in_valid = 1;
    step();
    in_data = 8'hC3; out_ack = 8'h08;
    step();
    in_valid = 0; out_ack = 8'h00;
    check("aw_valid", {56'd0, out_valid}, 64'h08);
    check("aw_lane3", {56'd0, lane(3)}, 64'hC3);
    sel = 3'd6; in_data = 8'h66; in_valid = 1; out_ack = 8'h08;
    step();
    in_valid = 0; out_ack = 8'h00;
    check("wa_other_valid", {56'd0, out_valid}, 64'h40);
    sel = 3'd7; in_data = 8'h77; in_valid = 1;
    step();
    in_valid = 0;
    check("sel7_no_frame", {63'd0, frame_done}, 64'd0);
    check("sel7_lane7", {56'd0, lane(7)}, 64'h77);

    // Mid-operation reset
    rst_n = 0;
    step();
    rst_n = 1; auto = 1; in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(8'hD0 + i);
      step();
    end
    check("mr_ptr4", {61'd0, ptr}, 64'd4);
    check("mr_valid0f", {56'd0, out_valid}, 64'h0F);
    rst_n = 0; out_ack = 8'hFF;
    step();
    check("mr_valid", {56'd0, out_valid}, 64'h00);
    check("mr_ptr", {61'd0, ptr}, 64'd0);
    check("mr_frame", {63'd0, frame_done}, 64'd0);
    check("mr_bus", out_bus, 64'd0);
    rst_n = 1; in_valid = 0; out_ack = 8'h00;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
